// File: rtl/dtm_pkg.sv
// Shared types and constants for the JTAG DTM register block (dtmcs/dmi layouts, FSM states, error codes).
package dtm_pkg;

  localparam int unsigned ABITS   = 7;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned DTMCS_W = 32;
  localparam int unsigned DMI_W   = ABITS + DATA_W + OP_W;

  typedef enum logic [1:0] {
    OP_NOP      = 2'd0,
    OP_READ     = 2'd1,
    OP_WRITE    = 2'd2,
    OP_RESERVED = 2'd3
  } dtm_op_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ       = 3'd1,
    ST_WAIT_READ  = 3'd2,
    ST_WRITE      = 3'd3,
    ST_WAIT_WRITE = 3'd4
  } dtm_state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_FAILED = 2'd2;
  localparam logic [1:0] ERR_BUSY   = 2'd3;

  typedef struct packed {
    logic [13:0] zero_hi;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero_15;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  typedef struct packed {
    logic [ABITS-1:0]  address;
    logic [DATA_W-1:0] data;
    dtm_op_e           op;
  } dmi_t;

  // Read-back value of dtmcs; the reset request bits always read as zero.
  function automatic dtmcs_t dtmcs_value(input logic [2:0] idle, input logic [3:0] version,
                                         input logic [1:0] err);
    dtmcs_t v;
    v         = '0;
    v.version = version;
    v.abits   = 6'(ABITS);
    v.dmistat = err;
    v.idle    = idle;
    return v;
  endfunction

endpackage

// File: rtl/dtm_shift_reg.sv
// Generic TAP data shift register: clear, parallel capture, right shift with tdi into the MSB.
module dtm_shift_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             capture,
  input  logic             shift,
  input  logic             tdi,
  input  logic [Width-1:0] capture_data,
  output logic [Width-1:0] q,
  output logic             tdo
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (capture) begin
      q <= capture_data;
    end else if (shift) begin
      q <= {tdi, q[Width-1:1]};
    end
  end

  assign tdo = q[0];

endmodule

// File: rtl/dtm_dmi_regs.sv
// DTM dtmcs/dmi scan registers plus the DMI request/response handshake FSM.
// Optional build macro DTM_HARDRESET_EN: dtmcs.dmihardreset performs the full DMI clear.
module dtm_dmi_regs
  import dtm_pkg::*;
#(
  parameter logic [2:0] IdleHint   = 3'd1,
  parameter logic [3:0] DmiVersion = 4'd1
) (
  input  logic              tck_i,
  input  logic              trst_i,
  input  logic              dmi_clear_i,
  input  logic              capture_i,
  input  logic              shift_i,
  input  logic              update_i,
  input  logic              tdi_i,
  input  logic              dtmcs_select_i,
  input  logic              dmi_select_i,
  output logic              dtmcs_tdo_o,
  output logic              dmi_tdo_o,
  output logic              dmi_req_valid_o,
  output logic [ABITS-1:0]  dmi_req_addr_o,
  output logic [DATA_W-1:0] dmi_req_data_o,
  output logic [OP_W-1:0]   dmi_req_op_o,
  input  logic              dmi_req_ready_i,
  input  logic              dmi_resp_valid_i,
  input  logic [DATA_W-1:0] dmi_resp_data_i,
  input  logic [OP_W-1:0]   dmi_resp_resp_i,
  output logic              dmi_resp_ready_o
);

  dtm_state_e         state_q, state_d;
  logic [1:0]         err_q, err_d;
  logic [ABITS-1:0]   last_addr_q, last_addr_d;
  logic [DATA_W-1:0]  last_rdata_q, last_rdata_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               req_valid_q, req_valid_d;
  dtm_op_e            req_op_q, req_op_d;
  logic               resp_ready_q, resp_ready_d;

  logic [DTMCS_W-1:0] dtmcs_q, dtmcs_capture;
  logic [DMI_W-1:0]   dmi_q, dmi_capture;
  dtmcs_t             dtmcs_in;
  dmi_t               dmi_in;
  logic               dtmcs_upd, dmi_upd, hard_clear, clear_all;
  logic               unused_dtmcs;

  assign dtmcs_in  = dtmcs_t'(dtmcs_q);
  assign dmi_in    = dmi_t'(dmi_q);
  assign dtmcs_upd = update_i & dtmcs_select_i;
  assign dmi_upd   = update_i & dmi_select_i;

`ifdef DTM_HARDRESET_EN
  assign hard_clear = dtmcs_upd & dtmcs_in.dmihardreset;
`else
  assign hard_clear = 1'b0;
`endif

  assign clear_all = dmi_clear_i | hard_clear;

  // Only the reset request bits of a written dtmcs value have any effect.
  assign unused_dtmcs = ^{dtmcs_in.zero_hi, dtmcs_in.dmihardreset, dtmcs_in.zero_15,
                          dtmcs_in.idle, dtmcs_in.dmistat, dtmcs_in.abits, dtmcs_in.version};

  // A capture while a transaction is in flight reports busy in the op field.
  assign dtmcs_capture = DTMCS_W'(dtmcs_value(IdleHint, DmiVersion, err_q));
  assign dmi_capture   = {last_addr_q, last_rdata_q, (state_q == ST_IDLE) ? err_q : ERR_BUSY};

  dtm_shift_reg #(.Width(DTMCS_W)) u_dtmcs_sr (
    .clk          (tck_i),
    .rst          (trst_i),
    .clear        (clear_all),
    .capture      (capture_i & dtmcs_select_i),
    .shift        (shift_i & dtmcs_select_i),
    .tdi          (tdi_i),
    .capture_data (dtmcs_capture),
    .q            (dtmcs_q),
    .tdo          (dtmcs_tdo_o)
  );

  dtm_shift_reg #(.Width(DMI_W)) u_dmi_sr (
    .clk          (tck_i),
    .rst          (trst_i),
    .clear        (clear_all),
    .capture      (capture_i & dmi_select_i),
    .shift        (shift_i & dmi_select_i),
    .tdi          (tdi_i),
    .capture_data (dmi_capture),
    .q            (dmi_q),
    .tdo          (dmi_tdo_o)
  );

  // Next state: bus handshake first, then scan updates, then clear (later assignments win).
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    last_addr_d  = last_addr_q;
    last_rdata_d = last_rdata_q;
    wdata_d      = wdata_q;
    req_valid_d  = 1'b0;
    req_op_d     = OP_NOP;
    resp_ready_d = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_READ: begin
        if (dmi_req_ready_i) state_d = ST_WAIT_READ;
      end
      ST_WRITE: begin
        if (dmi_req_ready_i) state_d = ST_WAIT_WRITE;
      end
      ST_WAIT_READ: begin
        if (dmi_resp_valid_i) begin
          state_d      = ST_IDLE;
          last_rdata_d = dmi_resp_data_i;
          if ((dmi_resp_resp_i != 2'd0) && (err_q != ERR_BUSY)) err_d = ERR_FAILED;
        end
      end
      ST_WAIT_WRITE: begin
        if (dmi_resp_valid_i) begin
          state_d = ST_IDLE;
          if ((dmi_resp_resp_i != 2'd0) && (err_q != ERR_BUSY)) err_d = ERR_FAILED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (dmi_upd) begin
      if (state_q != ST_IDLE) begin
        err_d = ERR_BUSY;
      end else if (err_q == ERR_NONE) begin
        last_addr_d = dmi_in.address;
        wdata_d     = dmi_in.data;
        if (dmi_in.op == OP_READ) begin
          state_d = ST_READ;
        end else if (dmi_in.op == OP_WRITE) begin
          state_d = ST_WRITE;
        end
      end
    end

    if (dtmcs_upd && dtmcs_in.dmireset) err_d = ERR_NONE;

    if (clear_all) begin
      state_d      = ST_IDLE;
      err_d        = ERR_NONE;
      last_addr_d  = '0;
      last_rdata_d = '0;
    end

    // Handshake outputs are registered copies of the next-state decode.
    case (state_d)
      ST_READ: begin
        req_valid_d = 1'b1;
        req_op_d    = OP_READ;
      end
      ST_WRITE: begin
        req_valid_d = 1'b1;
        req_op_d    = OP_WRITE;
      end
      ST_WAIT_READ, ST_WAIT_WRITE: resp_ready_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q      <= ST_IDLE;
      err_q        <= ERR_NONE;
      last_addr_q  <= '0;
      last_rdata_q <= '0;
      wdata_q      <= '0;
      req_valid_q  <= 1'b0;
      req_op_q     <= OP_NOP;
      resp_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      last_addr_q  <= last_addr_d;
      last_rdata_q <= last_rdata_d;
      wdata_q      <= wdata_d;
      req_valid_q  <= req_valid_d;
      req_op_q     <= req_op_d;
      resp_ready_q <= resp_ready_d;
    end
  end

  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_req_addr_o   = last_addr_q;
  assign dmi_req_data_o   = wdata_q;
  assign dmi_req_op_o     = OP_W'(req_op_q);
  assign dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_dtm_dmi_regs.sv
// Self-checking bench for dtm_dmi_regs: directed scenarios plus randomized DMI traffic vs a transaction-level model.
module tb_dtm_dmi_regs;

`ifdef DTM_HARDRESET_EN
  localparam bit HardEn = 1'b1;
`else
  localparam bit HardEn = 1'b0;
`endif

  logic        tck = 1'b0;
  logic        trst;
  logic        dmi_clear, capture, shift, update, tdi, dtmcs_select, dmi_select;
  logic        dtmcs_tdo, dmi_tdo;
  logic        req_valid, req_ready, resp_valid, resp_ready;
  logic [6:0]  req_addr;
  logic [31:0] req_data, resp_data;
  logic [1:0]  req_op, resp_resp;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Transaction-level model of the architectural state.
  logic [1:0]  m_err   = 2'd0;
  logic [6:0]  m_addr  = 7'd0;
  logic [31:0] m_rdata = 32'd0;

  always #5 tck = ~tck;

  dtm_dmi_regs dut (
    .tck_i            (tck),
    .trst_i           (trst),
    .dmi_clear_i      (dmi_clear),
    .capture_i        (capture),
    .shift_i          (shift),
    .update_i         (update),
    .tdi_i            (tdi),
    .dtmcs_select_i   (dtmcs_select),
    .dmi_select_i     (dmi_select),
    .dtmcs_tdo_o      (dtmcs_tdo),
    .dmi_tdo_o        (dmi_tdo),
    .dmi_req_valid_o  (req_valid),
    .dmi_req_addr_o   (req_addr),
    .dmi_req_data_o   (req_data),
    .dmi_req_op_o     (req_op),
    .dmi_req_ready_i  (req_ready),
    .dmi_resp_valid_i (resp_valid),
    .dmi_resp_data_i  (resp_data),
    .dmi_resp_resp_i  (resp_resp),
    .dmi_resp_ready_o (resp_ready)
  );

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_dtmcs(input logic [1:0] e);
    return (32'd1 << 12) | (32'(e) << 10) | (32'd7 << 4) | 32'd1;
  endfunction

  // Capture, shift len bits (collecting tdo), then update.
  task automatic scan(input bit is_dmi, input logic [40:0] din, input int len,
                      output logic [40:0] dout);
    dout         = '0;
    dmi_select   = is_dmi;
    dtmcs_select = !is_dmi;
    capture      = 1'b1;
    tick();
    capture = 1'b0;
    shift   = 1'b1;
    for (int i = 0; i < len; i++) begin
      tdi     = din[i];
      dout[i] = is_dmi ? dmi_tdo : dtmcs_tdo;
      tick();
    end
    shift  = 1'b0;
    update = 1'b1;
    tick();
    update       = 1'b0;
    dmi_select   = 1'b0;
    dtmcs_select = 1'b0;
  endtask

  task automatic dtmcs_scan(input logic [31:0] din);
    logic [40:0] dout;
    scan(1'b0, {9'd0, din}, 32, dout);
    chk("dtmcs_capture", 64'(dout[31:0]), 64'(exp_dtmcs(m_err)));
    if (din[16]) m_err = 2'd0;
    if (HardEn && din[17]) begin
      m_err   = 2'd0;
      m_addr  = 7'd0;
      m_rdata = 32'd0;
    end
  endtask

  // One DMI access from Idle: scan in, handshake with the given delays, update the model.
  task automatic txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                     input int rdy_dly, input int rsp_dly, input bit early,
                     input logic [1:0] rresp, input logic [31:0] rdata);
    logic [40:0] dout;
    bit go;
    scan(1'b1, {addr, data, op}, 41, dout);
    chk("dmi_capture", 64'(dout), 64'({m_addr, m_rdata, m_err}));
    go = (m_err == 2'd0) && (op == 2'd1 || op == 2'd2);
    if (m_err == 2'd0) m_addr = addr;
    chk("req_valid", 64'(req_valid), 64'(go));
    if (go) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        chk("req_payload", 64'({req_valid, req_addr, req_data, req_op, resp_ready}),
            64'({1'b1, addr, data, op, 1'b0}));
        if (i < rdy_dly) tick();
      end
      req_ready  = 1'b1;
      resp_valid = early;
      resp_data  = rdata;
      resp_resp  = rresp;
      tick();
      req_ready = 1'b0;
      chk("req_accepted", 64'({req_valid, resp_ready}), 64'(2'b01));
      if (!early) begin
        for (int i = 0; i < rsp_dly; i++) begin
          tick();
          chk("resp_wait", 64'({req_valid, resp_ready}), 64'(2'b01));
        end
      end
      resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0;
      chk("resp_taken", 64'({req_valid, resp_ready}), 64'(2'b00));
      if (op == 2'd1) m_rdata = rdata;
      if (rresp != 2'd0 && m_err != 2'd3) m_err = 2'd2;
    end else begin
      tick();
      chk("req_idle", 64'({req_valid, resp_ready}), 64'(2'b00));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [40:0] d;
    logic [31:0] w;

    trst = 1'b1;
    {dmi_clear, capture, shift, update, tdi, dtmcs_select, dmi_select} = '0;
    {req_ready, resp_valid, resp_data, resp_resp} = '0;
    #2;
    chk("reset_outputs", 64'({dtmcs_tdo, dmi_tdo, req_valid, req_addr, req_data, req_op, resp_ready}), 64'd0);
    capture = 1'b1; dtmcs_select = 1'b1; dmi_select = 1'b1;
    tick();
    tick();
    chk("reset_hold", 64'({dtmcs_tdo, dmi_tdo, req_valid, req_addr, req_data, req_op, resp_ready}), 64'd0);
    capture = 1'b0; dtmcs_select = 1'b0; dmi_select = 1'b0;
    trst = 1'b0;
    tick();

    // dtmcs read-back after reset
    dtmcs_scan(32'd0);

    // write of 1 to 0x10, accepted immediately, ok response
    txn(2'd2, 7'h10, 32'h0000_0001, 0, 0, 1'b0, 2'd0, 32'd0);
    // read of 0x11, response arrives together with ready (taken a cycle later)
    txn(2'd1, 7'h11, 32'h0, 0, 2, 1'b1, 2'd0, 32'hCAFE_F00D);
    txn(2'd0, 7'h11, 32'h0, 0, 0, 1'b0, 2'd0, 32'd0);
    txn(2'd0, 7'h11, 32'h0, 0, 0, 1'b0, 2'd0, 32'd0);

    // busy: second dmi update while waiting for a read response
    scan(1'b1, {7'h12, 32'h0, 2'd1}, 41, d);
    chk("busy_pre_capture", 64'(d), 64'({m_addr, m_rdata, m_err}));
    m_addr    = 7'h12;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("busy_wait_read", 64'(resp_ready), 64'd1);
    scan(1'b1, {7'h55, 32'h1234, 2'd2}, 41, d);
    chk("busy_capture_op3", 64'(d), 64'({7'h12, m_rdata, 2'd3}));
    m_err      = 2'd3;
    resp_valid = 1'b1;
    resp_data  = 32'h0BAD_BEEF;
    resp_resp  = 2'd0;
    tick();
    resp_valid = 1'b0;
    m_rdata    = 32'h0BAD_BEEF;
    txn(2'd1, 7'h13, 32'h0, 0, 0, 1'b0, 2'd0, 32'd0);
    dtmcs_scan(32'h0001_0000);
    txn(2'd0, 7'h12, 32'h0, 0, 0, 1'b0, 2'd0, 32'd0);

    // failed response sets dmistat=2 and blocks further requests until dmireset
    txn(2'd2, 7'h20, 32'hA5A5_0000, 1, 1, 1'b0, 2'd2, 32'd0);
    dtmcs_scan(32'd0);
    txn(2'd2, 7'h21, 32'h1, 0, 0, 1'b0, 2'd0, 32'd0);
    dtmcs_scan(32'hFFFD_FFFF);

    // dmi_clear while a read waits for ready
    scan(1'b1, {7'h22, 32'h5, 2'd1}, 41, d);
    chk("clear_pre_capture", 64'(d), 64'({m_addr, m_rdata, m_err}));
    chk("clear_pre_valid", 64'(req_valid), 64'd1);
    dmi_clear = 1'b1;
    tick();
    dmi_clear = 1'b0;
    chk("clear_drop_valid", 64'({req_valid, resp_ready}), 64'd0);
    m_err = 2'd0; m_addr = 7'd0; m_rdata = 32'd0;
    txn(2'd0, 7'h00, 32'h0, 0, 0, 1'b0, 2'd0, 32'd0);

    // dmihardreset while a read waits for ready
    txn(2'd1, 7'h23, 32'h0, 0, 0, 1'b0, 2'd0, 32'h7777_0001);
    scan(1'b1, {7'h24, 32'h6, 2'd1}, 41, d);
    m_addr = 7'h24;
    dtmcs_scan(32'h0002_0000);
    chk("hardreset_valid", 64'(req_valid), 64'(!HardEn));
    dmi_clear = 1'b1;
    tick();
    dmi_clear = 1'b0;
    m_err = 2'd0; m_addr = 7'd0; m_rdata = 32'd0;
    txn(2'd0, 7'h00, 32'h0, 0, 0, 1'b0, 2'd0, 32'd0);

    // reset in the middle of a read abandons it
    txn(2'd1, 7'h31, 32'h0, 0, 0, 1'b0, 2'd0, 32'h1111_2222);
    scan(1'b1, {7'h33, 32'h0, 2'd1}, 41, d);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("midreset_wait", 64'(resp_ready), 64'd1);
    trst = 1'b1;
    #2;
    chk("midreset_outputs", 64'({dtmcs_tdo, dmi_tdo, req_valid, req_addr, req_data, req_op, resp_ready}), 64'd0);
    tick();
    trst = 1'b0;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    chk("midreset_no_pending", 64'({req_valid, resp_ready}), 64'd0);
    m_err = 2'd0; m_addr = 7'd0; m_rdata = 32'd0;
    txn(2'd0, 7'h00, 32'h0, 0, 0, 1'b0, 2'd0, 32'd0);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      txn(2'($urandom_range(0, 3)), 7'($urandom), $urandom, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        w     = $urandom;
        w[17] = 1'b0;
        dtmcs_scan(w);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
